// File: rtl/rx78_pkg.sv
// Shared constants and types for the RX-78 keyboard/joystick matrix controller.
package rx78_pkg;

  localparam logic [7:0] KB_PORT  = 8'hF4;

  localparam logic [3:0] STB_NONE = 4'd0;
  localparam logic [3:0] STB_JOY1 = 4'd10;
  localparam logic [3:0] STB_JOY2 = 4'd11;
  localparam logic [3:0] STB_ALL  = 4'd15;

  typedef struct packed {
    logic       hit;
    logic [3:0] col;
    logic [2:0] row;
  } keypos_t;

  function automatic keypos_t key_at(input logic [3:0] col, input logic [2:0] row);
    keypos_t k;
    k.hit = 1'b1;
    k.col = col;
    k.row = row;
    return k;
  endfunction

endpackage

// File: rtl/rx78_keymap.sv
// PS/2 set-2 scancode to RX-78 matrix position; purely combinational table.
module rx78_keymap
  import rx78_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output keypos_t    pos
);

  always_comb begin
    pos = '0;
    case ({ext, code})
      // column 1: editing / control
      9'h05A: pos = key_at(4'd1, 3'd0);   // Enter
      9'h15A: pos = key_at(4'd1, 3'd0);   // keypad Enter shares the Enter key
      9'h029: pos = key_at(4'd1, 3'd1);   // Space
      9'h066: pos = key_at(4'd1, 3'd2);   // Backspace
      9'h076: pos = key_at(4'd1, 3'd3);   // Esc
      9'h00D: pos = key_at(4'd1, 3'd4);   // Tab
      // column 2: digits 1-8
      9'h016: pos = key_at(4'd2, 3'd0);
      9'h01E: pos = key_at(4'd2, 3'd1);
      9'h026: pos = key_at(4'd2, 3'd2);
      9'h025: pos = key_at(4'd2, 3'd3);
      9'h02E: pos = key_at(4'd2, 3'd4);
      9'h036: pos = key_at(4'd2, 3'd5);
      9'h03D: pos = key_at(4'd2, 3'd6);
      9'h03E: pos = key_at(4'd2, 3'd7);
      // column 3: 9, 0, QWERTY
      9'h046: pos = key_at(4'd3, 3'd0);
      9'h045: pos = key_at(4'd3, 3'd1);
      9'h015: pos = key_at(4'd3, 3'd2);
      9'h01D: pos = key_at(4'd3, 3'd3);
      9'h024: pos = key_at(4'd3, 3'd4);
      9'h02D: pos = key_at(4'd3, 3'd5);
      9'h02C: pos = key_at(4'd3, 3'd6);
      9'h035: pos = key_at(4'd3, 3'd7);
      // column 4: U, A, S, D, F, G, H, J
      9'h03C: pos = key_at(4'd4, 3'd0);
      9'h01C: pos = key_at(4'd4, 3'd1);
      9'h01B: pos = key_at(4'd4, 3'd2);
      9'h023: pos = key_at(4'd4, 3'd3);
      9'h02B: pos = key_at(4'd4, 3'd4);
      9'h034: pos = key_at(4'd4, 3'd5);
      9'h033: pos = key_at(4'd4, 3'd6);
      9'h03B: pos = key_at(4'd4, 3'd7);
      // column 5: K, L, Z, X, C, V, B, N
      9'h042: pos = key_at(4'd5, 3'd0);
      9'h04B: pos = key_at(4'd5, 3'd1);
      9'h01A: pos = key_at(4'd5, 3'd2);
      9'h022: pos = key_at(4'd5, 3'd3);
      9'h021: pos = key_at(4'd5, 3'd4);
      9'h02A: pos = key_at(4'd5, 3'd5);
      9'h032: pos = key_at(4'd5, 3'd6);
      9'h031: pos = key_at(4'd5, 3'd7);
      // column 6: M, I, O, P and punctuation
      9'h03A: pos = key_at(4'd6, 3'd0);
      9'h043: pos = key_at(4'd6, 3'd1);
      9'h044: pos = key_at(4'd6, 3'd2);
      9'h04D: pos = key_at(4'd6, 3'd3);
      9'h041: pos = key_at(4'd6, 3'd4);
      9'h049: pos = key_at(4'd6, 3'd5);
      9'h04A: pos = key_at(4'd6, 3'd6);
      9'h04E: pos = key_at(4'd6, 3'd7);
      // column 7: remaining punctuation, F1/F2
      9'h04C: pos = key_at(4'd7, 3'd0);
      9'h052: pos = key_at(4'd7, 3'd1);
      9'h054: pos = key_at(4'd7, 3'd2);
      9'h05B: pos = key_at(4'd7, 3'd3);
      9'h055: pos = key_at(4'd7, 3'd4);
      9'h05D: pos = key_at(4'd7, 3'd5);
      9'h005: pos = key_at(4'd7, 3'd6);
      9'h006: pos = key_at(4'd7, 3'd7);
      // column 8: cursor cluster (extended codes) and F3
      9'h16B: pos = key_at(4'd8, 3'd0);
      9'h174: pos = key_at(4'd8, 3'd1);
      9'h175: pos = key_at(4'd8, 3'd2);
      9'h172: pos = key_at(4'd8, 3'd3);
      9'h16C: pos = key_at(4'd8, 3'd4);
      9'h170: pos = key_at(4'd8, 3'd5);
      9'h171: pos = key_at(4'd8, 3'd6);
      9'h004: pos = key_at(4'd8, 3'd7);
      // column 9: modifiers; both shifts and both ctrls fold together
      9'h012: pos = key_at(4'd9, 3'd0);
      9'h059: pos = key_at(4'd9, 3'd0);
      9'h014: pos = key_at(4'd9, 3'd1);
      9'h114: pos = key_at(4'd9, 3'd1);
      9'h011: pos = key_at(4'd9, 3'd2);
      default: pos = '0;
    endcase
  end

endmodule

// File: rtl/rx78_keyboard.sv
// RX-78 keyboard/joystick matrix: PS/2 events into a column x row key matrix,
// CPU column strobe and row read on one I/O port, OR-able read bus.
module rx78_keyboard
  import rx78_pkg::*;
#(
  parameter logic [7:0] PORT_ADDR = KB_PORT,
  parameter int         NCOLS     = 9,
  parameter bit         JOY_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [7:0]  joy1,
  input  logic [7:0]  joy2,
  input  logic        ziorq,
  input  logic        zwr,
  input  logic [7:0]  zaddr,
  input  logic [7:0]  zdo,
  output logic [7:0]  kb_q,
  output logic [3:0]  strobe
);

  logic                  tog_prev_reg;
  logic                  ev;
  logic                  v1_reg;
  logic                  s1_ext_reg;
  logic                  s1_press_reg;
  logic [7:0]            s1_code_reg;
  keypos_t               s1_pos;
  logic                  v2_reg;
  logic                  s2_press_reg;
  keypos_t               s2_pos_reg;
  logic [NCOLS-1:0][7:0] matrix_reg;
  logic [NCOLS-1:0]      col_wr;
  logic [3:0]            strobe_reg;
  logic [7:0]            kb_q_reg;
  logic [7:0]            all_cols;
  logic [7:0]            rowsel;
  logic                  io_sel;
  logic                  wr_sel;
  logic                  rd_sel;
  logic                  unused_joy_bits;

  assign ev = ps2_key[10] ^ tog_prev_reg;
  assign unused_joy_bits = ^{joy1[7:6], joy2[7:6]};

  rx78_keymap u_keymap (
    .ext  (s1_ext_reg),
    .code (s1_code_reg),
    .pos  (s1_pos)
  );

  // Stage 0 captures the event, stage 1 registers the lookup result.
  // tog_prev reloads from the live bit in reset so no event fires on release.
  always_ff @(posedge clk) begin
    if (reset) begin
      tog_prev_reg <= ps2_key[10];
      v1_reg       <= 1'b0;
      s1_ext_reg   <= 1'b0;
      s1_press_reg <= 1'b0;
      s1_code_reg  <= 8'h00;
      v2_reg       <= 1'b0;
      s2_press_reg <= 1'b0;
      s2_pos_reg   <= '0;
    end else begin
      tog_prev_reg <= ps2_key[10];
      v1_reg       <= ev;
      if (ev) begin
        s1_ext_reg   <= ps2_key[8];
        s1_press_reg <= ps2_key[9];
        s1_code_reg  <= ps2_key[7:0];
      end
      v2_reg       <= v1_reg & s1_pos.hit;
      s2_pos_reg   <= s1_pos;
      s2_press_reg <= s1_press_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCOLS; gi++) begin : g_col_wr
      assign col_wr[gi] = v2_reg && (s2_pos_reg.col == 4'(gi + 1));
    end
  endgenerate

  // Stage 2: the matrix write. Column codes are 1-based, storage is 0-based.
  always_ff @(posedge clk) begin
    if (reset) begin
      matrix_reg <= '0;
    end else begin
      for (int c = 0; c < NCOLS; c++) begin
        if (col_wr[c]) matrix_reg[c][s2_pos_reg.row] <= s2_press_reg;
      end
    end
  end

  always_comb begin
    all_cols = 8'h00;
    for (int c = 0; c < NCOLS; c++) all_cols = all_cols | matrix_reg[c];
  end

  always_comb begin
    rowsel = 8'h00;
    if (strobe_reg == STB_ALL) begin
      rowsel = all_cols;
    end else if (JOY_EN && strobe_reg == STB_JOY1) begin
      rowsel = {2'b00, joy1[5:0]};
    end else if (JOY_EN && strobe_reg == STB_JOY2) begin
      rowsel = {2'b00, joy2[5:0]};
    end else begin
      for (int c = 0; c < NCOLS; c++) begin
        if (strobe_reg == 4'(c + 1)) rowsel = matrix_reg[c];
      end
    end
  end

  assign io_sel = ~ziorq & (zaddr == PORT_ADDR);
  assign wr_sel = io_sel & ~zwr;
  assign rd_sel = io_sel & zwr;

  // kb_q drops to zero whenever the port is not being read so it can be ORed.
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_reg <= STB_NONE;
      kb_q_reg   <= 8'h00;
    end else begin
      if (wr_sel) strobe_reg <= (zdo == 8'h30) ? STB_ALL : zdo[3:0];
      kb_q_reg <= rd_sel ? rowsel : 8'h00;
    end
  end

  assign kb_q   = kb_q_reg;
  assign strobe = strobe_reg;

endmodule

// File: tb/tb_rx78_keyboard.sv
// Self-checking bench for rx78_keyboard: vector table plus hand-written
// latency, reset and pipeline sequences; reads scored through a queue.
module tb_rx78_keyboard;

  logic        clk;
  logic        reset;
  logic [10:0] ps2_key;
  logic [7:0]  joy1;
  logic [7:0]  joy2;
  logic        ziorq;
  logic        zwr;
  logic [7:0]  zaddr;
  logic [7:0]  zdo;
  logic [7:0]  kb_q;
  logic [3:0]  strobe;
  logic [7:0]  kb_q_nj;
  logic [3:0]  strobe_nj;

  rx78_keyboard dut (
    .clk     (clk),
    .reset   (reset),
    .ps2_key (ps2_key),
    .joy1    (joy1),
    .joy2    (joy2),
    .ziorq   (ziorq),
    .zwr     (zwr),
    .zaddr   (zaddr),
    .zdo     (zdo),
    .kb_q    (kb_q),
    .strobe  (strobe)
  );

  rx78_keyboard #(.JOY_EN(1'b0)) dut_nj (
    .clk     (clk),
    .reset   (reset),
    .ps2_key (ps2_key),
    .joy1    (joy1),
    .joy2    (joy2),
    .ziorq   (ziorq),
    .zwr     (zwr),
    .zaddr   (zaddr),
    .zdo     (zdo),
    .kb_q    (kb_q_nj),
    .strobe  (strobe_nj)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] exp;
    logic [7:0] exp_nj;
    string      name;
  } sb_t;

  typedef struct {
    logic [7:0] zdo_v;
    logic [3:0] stb;
    logic [7:0] exp;
    logic [7:0] exp_nj;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[11];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Scoreboard: expectation queued as the read is driven, popped once the edge registers kb_q.
  task automatic read_cycle(input string name, input logic [7:0] exp, input logic [7:0] exp_nj);
    sb_t e;
    sb_q.push_back('{exp: exp, exp_nj: exp_nj, name: name});
    tick();
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      expect8(e.name, kb_q, e.exp);
      expect8({e.name, " nojoy"}, kb_q_nj, e.exp_nj);
    end
  endtask

  task automatic out_port(input logic [7:0] addr, input logic [7:0] v, input logic [3:0] exp_stb);
    ziorq = 1'b0;
    zwr   = 1'b0;
    zaddr = addr;
    zdo   = v;
    tick();
    ziorq = 1'b1;
    zwr   = 1'b1;
    expect8($sformatf("strobe after out %h,%h", addr, v), {4'h0, strobe}, {4'h0, exp_stb});
  endtask

  task automatic in_port(input logic [7:0] addr, input logic [7:0] exp, input logic [7:0] exp_nj,
                         input string name);
    ziorq = 1'b0;
    zwr   = 1'b1;
    zaddr = addr;
    read_cycle(name, exp, exp_nj);
    read_cycle({name, " hold"}, exp, exp_nj);
    ziorq = 1'b1;
    read_cycle({name, " idle"}, 8'h00, 8'h00);
  endtask

  task automatic key(input logic press, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], press, ext, code};
    tick();
  endtask

  task automatic settle();
    repeat (4) tick();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{zdo_v: 8'h0F, stb: 4'd15, exp: 8'h03, exp_nj: 8'h03};
    vecs[1]  = '{zdo_v: 8'h01, stb: 4'd1,  exp: 8'h01, exp_nj: 8'h01};
    vecs[2]  = '{zdo_v: 8'h04, stb: 4'd4,  exp: 8'h02, exp_nj: 8'h02};
    vecs[3]  = '{zdo_v: 8'h09, stb: 4'd9,  exp: 8'h01, exp_nj: 8'h01};
    vecs[4]  = '{zdo_v: 8'h02, stb: 4'd2,  exp: 8'h00, exp_nj: 8'h00};
    vecs[5]  = '{zdo_v: 8'h00, stb: 4'd0,  exp: 8'h00, exp_nj: 8'h00};
    vecs[6]  = '{zdo_v: 8'h0A, stb: 4'd10, exp: 8'h3F, exp_nj: 8'h00};
    vecs[7]  = '{zdo_v: 8'h0B, stb: 4'd11, exp: 8'h25, exp_nj: 8'h00};
    vecs[8]  = '{zdo_v: 8'h0C, stb: 4'd12, exp: 8'h00, exp_nj: 8'h00};
    vecs[9]  = '{zdo_v: 8'h30, stb: 4'd15, exp: 8'h03, exp_nj: 8'h03};
    vecs[10] = '{zdo_v: 8'h34, stb: 4'd4,  exp: 8'h02, exp_nj: 8'h02};

    reset   = 1'b1;
    ps2_key = 11'h000;
    joy1    = 8'h00;
    joy2    = 8'h00;
    ziorq   = 1'b1;
    zwr     = 1'b1;
    zaddr   = 8'h00;
    zdo     = 8'h00;
    repeat (3) tick();
    expect8("reset kb_q", kb_q, 8'h00);
    expect8("reset strobe", {4'h0, strobe}, 8'h00);
    reset = 1'b0;
    tick();

    // A make together with OUT F4,4, then a held IN F4 across the pipeline.
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
    ziorq = 1'b0;
    zwr   = 1'b0;
    zaddr = 8'hF4;
    zdo   = 8'h04;
    tick();
    expect8("latency strobe", {4'h0, strobe}, 8'h04);
    zwr = 1'b1;
    read_cycle("latency clk2", 8'h00, 8'h00);
    read_cycle("latency clk3 pre-update", 8'h00, 8'h00);
    read_cycle("latency clk4", 8'h02, 8'h02);
    ps2_key = {~ps2_key[10], 1'b0, 1'b0, 8'h1C};
    read_cycle("break clk1", 8'h02, 8'h02);
    read_cycle("break clk2", 8'h02, 8'h02);
    read_cycle("break clk3 pre-update", 8'h02, 8'h02);
    read_cycle("break clk4", 8'h00, 8'h00);
    ziorq = 1'b1;
    read_cycle("ziorq high", 8'h00, 8'h00);

    // Three makes on consecutive clocks, then the strobe/row vector table.
    key(1'b1, 1'b0, 8'h1C);
    key(1'b1, 1'b0, 8'h5A);
    key(1'b1, 1'b0, 8'h12);
    settle();
    joy1 = 8'hFF;
    joy2 = 8'hA5;
    for (int i = 0; i < 11; i++) begin
      out_port(8'hF4, vecs[i].zdo_v, vecs[i].stb);
      in_port(8'hF4, vecs[i].exp, vecs[i].exp_nj, $sformatf("vec%0d stb %0d", i, vecs[i].stb));
    end

    // Other port: no strobe change, and reads stay at zero with keys held.
    out_port(8'hF4, 8'h0F, 4'd15);
    out_port(8'hF5, 8'h04, 4'd15);
    in_port(8'hF5, 8'h00, 8'h00, "in port F5");

    // Release all, then unmapped 0x7E and non-extended 0x75 must leave nothing.
    key(1'b0, 1'b0, 8'h1C);
    key(1'b0, 1'b0, 8'h5A);
    key(1'b0, 1'b0, 8'h12);
    key(1'b1, 1'b0, 8'h7E);
    key(1'b1, 1'b0, 8'h75);
    settle();
    for (int c = 1; c <= 9; c++) begin
      out_port(8'hF4, 8'(c), 4'(c));
      in_port(8'hF4, 8'h00, 8'h00, $sformatf("unmapped col %0d", c));
    end

    key(1'b1, 1'b1, 8'h75);
    settle();
    out_port(8'hF4, 8'h08, 4'd8);
    in_port(8'hF4, 8'h04, 8'h04, "ext up col8");
    key(1'b0, 1'b1, 8'h75);
    settle();
    in_port(8'hF4, 8'h00, 8'h00, "ext up released");

    // Same key on consecutive clocks: the later event wins.
    out_port(8'hF4, 8'h04, 4'd4);
    key(1'b1, 1'b0, 8'h1C);
    key(1'b0, 1'b0, 8'h1C);
    settle();
    in_port(8'hF4, 8'h00, 8'h00, "make then break");
    key(1'b0, 1'b0, 8'h1C);
    key(1'b1, 1'b0, 8'h1C);
    settle();
    in_port(8'hF4, 8'h02, 8'h02, "break then make");
    key(1'b1, 1'b0, 8'h1C);
    settle();
    in_port(8'hF4, 8'h02, 8'h02, "repeat make");
    key(1'b0, 1'b0, 8'h1C);
    settle();

    // Reset while a make sits in stage 1, toggle bit left high.
    if (ps2_key[10]) key(1'b0, 1'b0, 8'h7E);
    settle();
    key(1'b1, 1'b0, 8'h1C);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    repeat (6) tick();
    expect8("post-reset strobe", {4'h0, strobe}, 8'h00);
    in_port(8'hF4, 8'h00, 8'h00, "post-reset strobe0 read");
    out_port(8'hF4, 8'h0F, 4'd15);
    in_port(8'hF4, 8'h00, 8'h00, "post-reset all cols");
    out_port(8'hF4, 8'h04, 4'd4);
    in_port(8'hF4, 8'h00, 8'h00, "post-reset col4");

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard leftover: %0d entries, expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx78_keyboard.md
Name: rx78_keyboard

Overview:
- Keyboard/joystick matrix controller on the Z80 I/O bus, a peer of the top-level I/O decoder at ports F1–FE.
- Consumes MiSTer PS/2 key events and joystick bits, and maintains a 9-column x 8-row pressed-key matrix.
- Answers CPU column-strobe writes and row reads on port F4.
- Drives an OR-able read bus: zero when not selected, so the top level ORs it into the CPU data-in mux alongside io_q.

Parameters:
- PORT_ADDR, 8'hF4, I/O address (A[7:0]) for strobe write and row read.
- NCOLS, 9, number of keyboard columns (strobe codes 1..NCOLS).
- JOY_EN, 1, when 1, strobe codes 10 and 11 return joystick 1 and joystick 2 bits.

Ports:
- clk  in  1  system clock; same clock as the CPU.
- reset  in  1  synchronous, active-high reset.
- ps2_key  in  11  [10] toggles on each event, [9] 1=press, [8] extended, [7:0] scancode.
- joy1  in  8  [0]up [1]down [2]left [3]right [4]btn1 [5]btn2; [7:6] ignored. Active-high.
- joy2  in  8  same layout as joy1.
- ziorq  in  1  Z80 IORQ_n, active-low.
- zwr  in  1  Z80 WR_n, active-low.
- zaddr  in  8  CPU address low byte.
- zdo  in  8  CPU write data.
- kb_q  out  8  read data; 8'h00 when not selected.
- strobe  out  4  current column select (debug/visibility).

Behaviour:
- Reset (sync): matrix all 0, strobe=0, kb_q=0, pipeline valid flags=0, tog_prev<=ps2_key[10].
  - Loading tog_prev from the live bit means no phantom event fires after reset, including reset mid-event.
- Event detect (stage 0):
  - ev = ps2_key[10] ^ tog_prev; tog_prev updates every cycle.
  - On ev, register {ext, press, scancode} and set v1.
- Lookup (stage 1): sub-module rx78_keymap maps {ext,scancode} combinationally to {hit, col[3:0], row[2:0]}. Register the result and set v2 = v1 & hit.
- Update (stage 2): if v2, matrix[col][row] <= press.
  - Press-to-visible latency is 3 clocks after the toggle edge.
  - The pipeline is fully pipelined: events on consecutive cycles are all applied.
  - Two events on the same key in consecutive cycles: the later one wins.
- Unmapped scancodes (hit=0) are dropped silently and leave no state change.
- Make while already pressed, or break while already released: idempotent.
- Strobe write:
  - Condition: ~ziorq & ~zwr & zaddr==PORT_ADDR → strobe <= zdo[3:0] on that edge.
  - zdo[7:4] is ignored, except that zdo==8'h30 sets strobe to code 15 (all-columns).
  - The write holds for as long as the bus cycle lasts; re-latching the same value is harmless.
- Row read:
  - Every cycle kb_q <= 0, except when ~ziorq & zwr & zaddr==PORT_ADDR; then kb_q <= rowsel.
  - rowsel by strobe value:
    - 0: 8'h00.
    - 1..NCOLS: matrix[strobe-1].
    - 10/11 with JOY_EN: {2'b00, joy[5:0]} of joy1/joy2.
    - 15: OR of all columns.
    - Any other value: 8'h00.
  - kb_q is registered: valid one clock after selection and held for the whole IORQ window. The Z80 I/O cycle is ≥3 T-states, so one clock of latency is acceptable.
  - A read in the same cycle as a matrix update returns the pre-update value.
- Simultaneous write and read in one cycle cannot occur (zwr is exclusive).
- A write and a key event in the same cycle proceed independently.
- Bit sense: 1 = pressed. CPU-visible polarity is fixed here; any inversion is done in ROM-facing glue, not in this block.

Decomposition:
- Shared package rx78_pkg holds:
  - KB_PORT = 8'hF4;
  - strobe code constants STB_NONE=0, STB_JOY1=10, STB_JOY2=11, STB_ALL=15;
  - typedef keypos_t {logic hit; logic [3:0] col; logic [2:0] row;}.
- One sub-module, rx78_keymap: a pure case table {ext,scancode} → keypos_t, so the map is editable and unit-testable alone.
  - Fixed entries: 0x1C(A)→col4,row1; 0x5A(Enter)→col1,row0; 0x12(LShift)→col9,row0; ext 0x75(Up)→col8,row2.

Test Plan:
- Reset, toggle ps2_key={1,1,0,8'h1C}, then OUT F4,4 and IN F4 → kb_q=8'h02 from the 4th clock after the toggle; break event then re-read → 8'h00.
- Toggles on 3 consecutive clocks (A make, Enter make, LShift make), then strobe 15 → kb_q=8'h03; strobes 1/4/9 → 8'h01/8'h02/8'h01.
- Unmapped scancode 0x7E make → all nine columns read 8'h00; no X on kb_q.
- joy1=8'hFF with OUT F4,10 then IN → 8'h3F; with JOY_EN=0 → 8'h00.
- kb_q is 8'h00 whenever ziorq=1, and on IN from port F5 even with keys held; strobe 0 returns 8'h00.
- Assert reset while a make event is in stage 1, with ps2_key[10] left toggled → after release, the matrix is all 0 and stays 0 (no phantom event).
